// File: rtl/iob_mem_responder.sv
// IOb native bus responder backed by a word-addressed RAM.
// Byte-strobe writes, programmable read latency and write wait states,
// one outstanding access at a time.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | ready high (when cke_i), waiting for a request
//   RWAIT  | read accepted, counting down the remaining read latency
//   RESP   | rvalid high for one cycle, rdata valid
//   WSTALL | write committed, holding ready low for the wait states
module iob_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int READ_LAT   = 1,
  parameter int WRITE_WAIT = 0,
  parameter     HEXFILE    = "none"
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cke_i,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0]       req_i,
  output logic [DATA_W+1:0]                     resp_o
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int DEPTH   = 1 << MEM_ADDR_W;
  localparam int CNT_MAX = (READ_LAT > WRITE_WAIT) ? READ_LAT : WRITE_WAIT;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  // RWAIT covers READ_LAT-1 cycles, RESP is the last one.
  localparam int RD_INIT = (READ_LAT > 1) ? READ_LAT - 2 : 0;
  localparam int WR_INIT = (WRITE_WAIT > 0) ? WRITE_WAIT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RWAIT  = 2'd1,
    RESP   = 2'd2,
    WSTALL = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic                  req_valid;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [STRB_W-1:0]     req_wstrb;
  logic [MEM_ADDR_W-1:0] mem_idx;
  logic                  ready;
  logic                  rvalid;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  unused_addr;

  assign req_valid = req_i[ADDR_W+DATA_W+STRB_W];
  assign req_addr  = req_i[ADDR_W+DATA_W+STRB_W-1 -: ADDR_W];
  assign req_wdata = req_i[DATA_W+STRB_W-1 -: DATA_W];
  assign req_wstrb = req_i[STRB_W-1:0];

  // Upper address bits alias onto the array; the byte offset is ignored.
  assign mem_idx     = req_addr[MEM_ADDR_W+1:2];
  assign unused_addr = ^req_addr;

  assign ready     = cke_i & (state_q == IDLE);
  assign rvalid    = (state_q == RESP);
  assign accept    = req_valid & ready & ~rst_i;
  assign rd_accept = accept & (req_wstrb == '0);
  assign wr_accept = accept & (req_wstrb != '0);

  assign resp_o = {rdata_q, rvalid, ready};

  // Byte-lane write into the RAM at the accept edge; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (req_wstrb[i]) begin
          mem[mem_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read data is captured at acceptance and held until the next accepted read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_accept) begin
      rdata_q <= mem[mem_idx];
    end
  end

  // State and countdown registers; reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter load/decrement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rd_accept) begin
          if (READ_LAT <= 1) begin
            state_d = RESP;
          end else begin
            state_d = RWAIT;
            cnt_d   = CNT_W'(RD_INIT);
          end
        end else if (wr_accept && (WRITE_WAIT > 0)) begin
          state_d = WSTALL;
          cnt_d   = CNT_W'(WR_INIT);
        end
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      WSTALL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_mem_responder.sv
// Directed bench for iob_mem_responder: three instances with different
// latency/wait-state settings share one clock and one reset.
module tb_iob_mem_responder;

  localparam int REQ_W = 1 + 32 + 32 + 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cke  [3];
  logic [REQ_W-1:0] req  [3];
  logic [33:0]      resp [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iob_mem_responder #(.READ_LAT(1), .WRITE_WAIT(0)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke[0]), .req_i(req[0]), .resp_o(resp[0]));
  iob_mem_responder #(.READ_LAT(4), .WRITE_WAIT(2)) u_lat4 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke[1]), .req_i(req[1]), .resp_o(resp[1]));
  iob_mem_responder #(.READ_LAT(3), .WRITE_WAIT(0)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke[2]), .req_i(req[2]), .resp_o(resp[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ready_of(input int i);
    return {31'b0, resp[i][0]};
  endfunction

  function automatic logic [31:0] rvalid_of(input int i);
    return {31'b0, resp[i][1]};
  endfunction

  function automatic logic [31:0] rdata_of(input int i);
    return resp[i][33:2];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req[i] = {v, a, d, s};
  endtask

  task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int ww, input string tag);
    set_req(i, 1'b1, a, d, s);
    chk({tag, "_ready_pre"}, ready_of(i), 32'd1);
    tick();
    set_req(i, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int c = 0; c < ww; c++) begin
      chk({tag, "_stall_ready"}, ready_of(i), 32'd0);
      chk({tag, "_stall_rvalid"}, rvalid_of(i), 32'd0);
      tick();
    end
    chk({tag, "_ready_post"}, ready_of(i), 32'd1);
  endtask

  task automatic do_read(input int i, input logic [31:0] a, input int lat,
                         input logic [31:0] exp, input string tag);
    set_req(i, 1'b1, a, 32'h0, 4'h0);
    chk({tag, "_ready_pre"}, ready_of(i), 32'd1);
    tick();
    set_req(i, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int c = 1; c < lat; c++) begin
      chk({tag, "_wait_rvalid"}, rvalid_of(i), 32'd0);
      chk({tag, "_wait_ready"}, ready_of(i), 32'd0);
      tick();
    end
    chk({tag, "_rvalid"}, rvalid_of(i), 32'd1);
    chk({tag, "_rdata"}, rdata_of(i), exp);
    chk({tag, "_resp_ready"}, ready_of(i), 32'd0);
    tick();
    chk({tag, "_rvalid_drop"}, rvalid_of(i), 32'd0);
    chk({tag, "_ready_back"}, ready_of(i), 32'd1);
    chk({tag, "_rdata_hold"}, rdata_of(i), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cke[i] = 1'b1;
      req[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", ready_of(i), 32'd1);
      chk("rst_rvalid", rvalid_of(i), 32'd0);
      chk("rst_rdata", rdata_of(i), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Basic write then read, single-cycle latency.
    do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr_full");
    do_read(0, 32'h10, 1, 32'hDEADBEEF, "rd_full");

    // Back-to-back writes, second one with partial strobes.
    do_write(0, 32'h20, 32'h11223344, 4'hF, 0, "wr_base");
    do_write(0, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "wr_strb");
    do_read(0, 32'h20, 1, 32'h11BB33DD, "rd_strb");

    // Address aliasing above the array depth.
    do_write(0, 32'h0000_0004, 32'h5, 4'hF, 0, "wr_alias");
    do_read(0, 32'h0000_1004, 1, 32'h5, "rd_alias");

    // Clock enable low forces ready low even in IDLE.
    cke[0] = 1'b0;
    #1;
    chk("cke_idle_ready", ready_of(0), 32'd0);
    cke[0] = 1'b1;
    #1;
    chk("cke_idle_ready_back", ready_of(0), 32'd1);
    tick();

    // Write wait states and multi-cycle read latency.
    do_write(1, 32'h8, 32'h12345678, 4'hF, 2, "wr_wait");
    do_read(1, 32'h8, 4, 32'h12345678, "rd_lat4");

    // Freeze for three cycles while in RWAIT.
    do_write(2, 32'h40, 32'hCAFEF00D, 4'hF, 0, "wr_lat3");
    set_req(2, 1'b1, 32'h40, 32'h0, 4'h0);
    tick();
    set_req(2, 1'b0, 32'h0, 32'h0, 4'h0);
    cke[2] = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("frz_rvalid", rvalid_of(2), 32'd0);
      chk("frz_ready", ready_of(2), 32'd0);
      tick();
    end
    cke[2] = 1'b1;
    #1;
    chk("frz_resume0_rvalid", rvalid_of(2), 32'd0);
    tick();
    chk("frz_resume1_rvalid", rvalid_of(2), 32'd0);
    tick();
    chk("frz_rvalid_pulse", rvalid_of(2), 32'd1);
    chk("frz_rdata", rdata_of(2), 32'hCAFEF00D);
    tick();
    chk("frz_rvalid_single", rvalid_of(2), 32'd0);
    chk("frz_ready_back", ready_of(2), 32'd1);

    // Reset right after a read accept drops the pending read.
    set_req(2, 1'b1, 32'h40, 32'h0, 4'h0);
    tick();
    set_req(2, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrd_ready", ready_of(2), 32'd1);
    chk("rstrd_rvalid", rvalid_of(2), 32'd0);
    chk("rstrd_rdata", rdata_of(2), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rstrd_no_rvalid", rvalid_of(2), 32'd0);
    end
    do_read(2, 32'h40, 3, 32'hCAFEF00D, "rd_after_rst");
    do_read(0, 32'h10, 1, 32'hDEADBEEF, "rd_mem_kept");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
